// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO configuration sequencer and the I2C slave.
// Holds the FSM encoding, status bit positions and the register indices.
package gpio_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MUTE_WAIT = 3'd1,
    APPLY     = 3'd2,
    SETTLE    = 3'd3
  } state_t;

  localparam int STAT_BUSY    = 7;
  localparam int STAT_PENDING = 6;
  localparam int STAT_MUTE_N  = 5;

  localparam logic [7:0] REG_CFG0   = 8'h30;
  localparam logic [7:0] REG_CFG1   = 8'h31;
  localparam logic [7:0] REG_STATUS = 8'h34;

  function automatic logic [7:0] pack_status(input logic busy, input logic pending,
                                             input logic mute_n, input state_t st);
    return {busy, pending, mute_n, 2'b00, st};
  endfunction

endpackage

// File: rtl/gpio_cfg_sequencer_if.sv
// Configuration bytes in, applied relay/DAC config, mute and status out.
// The host side (register file or bench) is the master; the sequencer is the slave.
interface gpio_cfg_sequencer_if;
  logic [7:0] cfg0_async;
  logic [7:0] cfg1_async;
  logic [7:0] relay_cfg;
  logic [7:0] dac_cfg;
  logic       mute_n;
  logic       busy;
  logic [7:0] status;

  modport master (output cfg0_async, cfg1_async,
                  input  relay_cfg, dac_cfg, mute_n, busy, status);
  modport slave  (input  cfg0_async, cfg1_async,
                  output relay_cfg, dac_cfg, mute_n, busy, status);
endinterface

// File: rtl/cfg_sync_stable.sv
// 2-FF synchronizer for the 16 config bits plus a stability qualifier.
// pending_set/pending_clr are single-cycle strobes on the edge the value becomes stable.
module cfg_sync_stable #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] raw,
  input  logic [15:0] applied,
  output logic [15:0] target,
  output logic        pending_set,
  output logic        pending_clr
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  logic [15:0]   meta;
  logic [15:0]   s;
  logic [SW-1:0] stab_cnt;
  logic          reach;

  // s only changes on an edge where meta differs from it, so that is the restart condition.
  assign reach       = (meta == s) && (stab_cnt == SW'(STABLE_CYCLES - 1));
  assign pending_set = reach && (s != applied);
  assign pending_clr = reach && (s == applied);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= '0;
      s        <= '0;
      stab_cnt <= '0;
      target   <= '0;
    end else begin
      meta <= raw;
      s    <= meta;
      if (meta != s)
        stab_cnt <= '0;
      else if (stab_cnt != SW'(STABLE_CYCLES))
        stab_cnt <= stab_cnt + 1'b1;
      // A revert also refreshes target, so an in-flight APPLY rewrites the applied value.
      if (reach)
        target <= s;
    end
  end

endmodule

// File: rtl/gpio_cfg_sequencer.sv
// Applies I2C-written relay/DAC config inside a mute window (mute, wait, apply, settle, unmute).
// Optional GPIO_CFG_NOMUTE_EN: changes confined to NOMUTE_MASK bits are applied directly from IDLE.
module gpio_cfg_sequencer
  import gpio_cfg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int MUTE_CYCLES   = 4096,
  parameter int SETTLE_CYCLES = 65536,
  parameter int CNT_W         = 17
`ifdef GPIO_CFG_NOMUTE_EN
  , parameter logic [15:0] NOMUTE_MASK = 16'h0000
`endif
) (
  input logic                 clk,
  input logic                 rst_n,
  gpio_cfg_sequencer_if.slave bus
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic [7:0]       relay_q;
  logic [7:0]       dac_q;
  logic             mute_q;
  logic [15:0]      target;
  logic [15:0]      applied;
  logic             pending_set;
  logic             pending_clr;
  logic             direct;

  assign applied = {dac_q, relay_q};

  cfg_sync_stable #(.STABLE_CYCLES(STABLE_CYCLES)) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw         ({bus.cfg1_async, bus.cfg0_async}),
    .applied     (applied),
    .target      (target),
    .pending_set (pending_set),
    .pending_clr (pending_clr)
  );

`ifdef GPIO_CFG_NOMUTE_EN
  assign direct = (state == IDLE) && pending && (((target ^ applied) & ~NOMUTE_MASK) == 16'h0000);
`else
  assign direct = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SETTLE;
      cnt     <= CNT_W'(SETTLE_CYCLES - 1);
      pending <= 1'b0;
      relay_q <= 8'h00;
      dac_q   <= 8'h00;
      mute_q  <= 1'b0;
    end else begin
      // A new set on the same edge as a clear wins, so the newer target is not lost.
      if (pending_set)
        pending <= 1'b1;
      else if (pending_clr || direct || state == APPLY)
        pending <= 1'b0;

      case (state)
        IDLE: begin
          mute_q <= 1'b1;
          if (direct) begin
            {dac_q, relay_q} <= target;
          end else if (pending) begin
            mute_q <= 1'b0;
            cnt    <= CNT_W'(MUTE_CYCLES - 1);
            state  <= MUTE_WAIT;
          end
        end
        MUTE_WAIT: begin
          if (cnt == '0) state <= APPLY;
          else           cnt   <= cnt - 1'b1;
        end
        APPLY: begin
          {dac_q, relay_q} <= target;
          cnt              <= CNT_W'(SETTLE_CYCLES - 1);
          state            <= SETTLE;
        end
        SETTLE: begin
          if (pending) begin
            state <= APPLY;
          end else if (cnt == '0) begin
            mute_q <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          mute_q <= 1'b0;
          cnt    <= CNT_W'(SETTLE_CYCLES - 1);
          state  <= SETTLE;
        end
      endcase
    end
  end

  assign bus.relay_cfg = relay_q;
  assign bus.dac_cfg   = dac_q;
  assign bus.mute_n    = mute_q;
  assign bus.busy      = (state != IDLE);
  assign bus.status    = pack_status(state != IDLE, pending, mute_q, state);

endmodule
